// File: rtl/conv_pool_stage_if.sv
// Stream-in / SRAM-write bundle for conv_pool_stage.
// The master drives start/valid/result and the slave (the pooling stage) drives the rest.
interface conv_pool_stage_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_ADDR_WIDTH = 4
);
  logic                              i_start;
  logic                              i_valid;
  logic signed [DATA_WIDTH-1:0]      i_result;
  logic                              o_ready;
  logic                              o_wr_en;
  logic        [SRAM_ADDR_WIDTH-1:0] o_wr_addr;
  logic signed [DATA_WIDTH-1:0]      o_wr_data;
  logic                              o_done;

  modport master (
    output i_start, i_valid, i_result,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done
  );

  modport slave (
    input  i_start, i_valid, i_result,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done
  );
endinterface

// File: rtl/conv_pool_stage.sv
// 2x2 stride-2 signed max pooling of a raster conv stream into sequential SRAM writes.
// Optional macro CONV_POOL_RELU_EN clamps each accepted pixel to >= 0 before pooling.
module conv_pool_stage #(
  parameter int DATA_WIDTH      = 8,
  parameter int FMAP_W          = 4,
  parameter int FMAP_H          = 4,
  parameter int SRAM_ADDR_WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  conv_pool_stage_if.slave   bus,
  output logic [1:0]         o_dbg_state
);
  localparam int CW   = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
  localparam int RW   = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
  localparam int LB_N = FMAP_W / 2;
  localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE = SRAM_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        [CW-1:0]              col_q;
  logic        [RW-1:0]              row_q;
  logic signed [DATA_WIDTH-1:0]      pair_q;
  logic signed [DATA_WIDTH-1:0]      linebuf [0:LB_N-1];
  logic                              wr_en_q;
  logic        [SRAM_ADDR_WIDTH-1:0] wr_addr_q;
  logic signed [DATA_WIDTH-1:0]      wr_data_q;

  logic                              accept;
  logic                              last_px;
  logic signed [DATA_WIDTH-1:0]      pix_in;
  logic        [LBW-1:0]             lb_idx;
  logic signed [DATA_WIDTH-1:0]      pair_max;
  logic signed [DATA_WIDTH-1:0]      pool_max;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Handshake: a pixel is taken on a rising edge when i_valid and o_ready are both high
  // and i_start is low; o_ready is high for the whole RUN state, so there is no backpressure.
  assign accept  = bus.i_valid && (state_q == S_RUN) && !bus.i_start;
  assign last_px = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_start) state_d = S_RUN;
      S_RUN: begin
        if (bus.i_start)          state_d = S_RUN;
        else if (accept && last_px) state_d = S_DONE;
      end
      S_DONE:  if (bus.i_start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef CONV_POOL_RELU_EN
    pix_in = bus.i_result[DATA_WIDTH-1] ? '0 : bus.i_result;
`else
    pix_in = bus.i_result;
`endif
    lb_idx   = LBW'(col_q >> 1);
    pair_max = smax(pair_q, pix_in);
    pool_max = smax(linebuf[lb_idx], pair_max);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q     <= '0;
      row_q     <= '0;
      pair_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (bus.i_start) begin
        col_q     <= '0;
        row_q     <= '0;
        wr_addr_q <= '0;
      end else begin
        // Address reflects the write in flight, then steps past it.
        if (wr_en_q) wr_addr_q <= wr_addr_q + ADDR_ONE;
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
          end else begin
            col_q <= col_q + COL_ONE;
          end
          if (!col_q[0]) begin
            pair_q <= pix_in;
          end else if (row_q[0]) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= pool_max;
          end
        end
      end
    end
  end

  // Even rows park their horizontal maxima here for the odd row beneath.
  always_ff @(posedge i_clk) begin
    if (accept && col_q[0] && !row_q[0]) linebuf[lb_idx] <= pair_max;
  end

  assign bus.o_ready   = (state_q == S_RUN);
  assign bus.o_done    = (state_q == S_DONE);
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign o_dbg_state   = state_q;
endmodule

// File: tb/tb_conv_pool_stage.sv
// Bench for conv_pool_stage: a 4x4 instance and a 5x3 instance, random and directed frames
// checked against a frame-level max-pool model through per-instance expected queues.
module tb_conv_pool_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_pool_stage_if #(.DATA_WIDTH(8), .SRAM_ADDR_WIDTH(4)) bus_a ();
  conv_pool_stage_if #(.DATA_WIDTH(8), .SRAM_ADDR_WIDTH(4)) bus_b ();
  logic [1:0] dbg_a, dbg_b;

  conv_pool_stage #(.DATA_WIDTH(8), .FMAP_W(4), .FMAP_H(4), .SRAM_ADDR_WIDTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a.slave), .o_dbg_state(dbg_a));
  conv_pool_stage #(.DATA_WIDTH(8), .FMAP_W(5), .FMAP_H(3), .SRAM_ADDR_WIDTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b.slave), .o_dbg_state(dbg_b));

  int checks = 0;
  int errors = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_b[$];
  logic signed [7:0] pix [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [7:0] act_fn(input logic signed [7:0] p);
`ifdef CONV_POOL_RELU_EN
    return (p < 0) ? 8'sd0 : p;
`else
    return p;
`endif
  endfunction

  function automatic logic signed [7:0] max2(input logic signed [7:0] a, input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Every 2x2 block whose bottom-right pixel is among the first n pixels yields one write.
  task automatic push_exp(input int sel, input int w, input int h, input int n);
    logic [3:0] addr;
    logic signed [7:0] m;
    int base;
    addr = 4'd0;
    for (int br = 0; br < h / 2; br++) begin
      for (int bc = 0; bc < w / 2; bc++) begin
        base = 2 * br * w + 2 * bc;
        if (base + w + 1 < n) begin
          m = max2(max2(act_fn(pix[base]), act_fn(pix[base + 1])),
                   max2(act_fn(pix[base + w]), act_fn(pix[base + w + 1])));
          if (sel == 0) exp_q_a.push_back({addr, m});
          else          exp_q_b.push_back({addr, m});
          addr = addr + 4'd1;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus_a.o_wr_en === 1'b1) begin
      wr_cnt_a++;
      if (exp_q_a.size() == 0) check("unexpected_wr_a", 32'd1, 32'd0);
      else check("wr_a_addr_data", {20'd0, bus_a.o_wr_addr, bus_a.o_wr_data}, {20'd0, exp_q_a.pop_front()});
    end
    if (!rst && bus_b.o_wr_en === 1'b1) begin
      wr_cnt_b++;
      if (exp_q_b.size() == 0) check("unexpected_wr_b", 32'd1, 32'd0);
      else check("wr_b_addr_data", {20'd0, bus_b.o_wr_addr, bus_b.o_wr_data}, {20'd0, exp_q_b.pop_front()});
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic st, input logic v, input logic [7:0] d);
    if (sel == 0) begin bus_a.i_start = st; bus_a.i_valid = v; bus_a.i_result = d; end
    else          begin bus_b.i_start = st; bus_b.i_valid = v; bus_b.i_result = d; end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus_a.o_done : bus_b.o_done;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus_a.o_ready : bus_b.o_ready;
  endfunction

  function automatic int get_cnt(input int sel);
    return (sel == 0) ? wr_cnt_a : wr_cnt_b;
  endfunction

  task automatic drive_frame(input int sel, input int w, input int h, input int n,
                             input int gap, input logic junk_on_start);
    push_exp(sel, w, h, n);
    set_in(sel, 1'b1, junk_on_start, 8'h63);
    tick();
    check("ready_after_start", get_ready(sel), 1);
    check("done_clear_after_start", get_done(sel), 0);
    for (int i = 0; i < n; i++) begin
      set_in(sel, 1'b0, 1'b1, pix[i]);
      tick();
      set_in(sel, 1'b0, 1'b0, 8'h00);
      if (i == n - 1) check("done_after_last", get_done(sel), (n == w * h) ? 1 : 0);
      repeat (gap) tick();
    end
  endtask

  task automatic finish_frame(input int sel, input int c0, input int exp_writes);
    repeat (6) tick();
    check("queue_drained", (sel == 0) ? exp_q_a.size() : exp_q_b.size(), 0);
    check("write_pulses", get_cnt(sel) - c0, exp_writes);
    check("done_held", get_done(sel), 1);
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) pix[i] = 8'(i + 1);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) pix[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_reset_outputs(input int sel);
    if (sel == 0) begin
      check("rst_ready_a", bus_a.o_ready, 0);
      check("rst_wr_en_a", bus_a.o_wr_en, 0);
      check("rst_done_a", bus_a.o_done, 0);
      check("rst_addr_a", bus_a.o_wr_addr, 0);
      check("rst_data_a", bus_a.o_wr_data, 0);
    end else begin
      check("rst_ready_b", bus_b.o_ready, 0);
      check("rst_wr_en_b", bus_b.o_wr_en, 0);
      check("rst_done_b", bus_b.o_done, 0);
      check("rst_addr_b", bus_b.o_wr_addr, 0);
      check("rst_data_b", bus_b.o_wr_data, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst = 1'b0;
    tick();
    check("idle_ready_a", bus_a.o_ready, 0);

    // Ramp 1..16: 6, 8, 14, 16
    fill_ramp(16);
    c0 = wr_cnt_a;
    drive_frame(0, 4, 4, 16, 0, 1'b0);
    finish_frame(0, c0, 4);

    // Uniform -5
    for (int i = 0; i < 16; i++) pix[i] = -8'sd5;
    c0 = wr_cnt_a;
    drive_frame(0, 4, 4, 16, 0, 1'b0);
    finish_frame(0, c0, 4);

    // Mixed-sign top-left block; a junk pixel rides along with start and must be dropped
    fill_rand(16);
    pix[0] = -8'sd128; pix[1] = 8'sd127; pix[4] = 8'sd0; pix[5] = -8'sd1;
    c0 = wr_cnt_a;
    drive_frame(0, 4, 4, 16, 0, 1'b1);
    finish_frame(0, c0, 4);

    // Gapped ramp
    fill_ramp(16);
    c0 = wr_cnt_a;
    drive_frame(0, 4, 4, 16, 2, 1'b0);
    finish_frame(0, c0, 4);

    // Abort after 6 pixels: the 6th closes block (0,0), so one write precedes the restart
    c0 = wr_cnt_a;
    drive_frame(0, 4, 4, 6, 0, 1'b0);
    drive_frame(0, 4, 4, 16, 0, 1'b0);
    finish_frame(0, c0, 5);

    // Pixels offered in DONE are ignored
    c0 = wr_cnt_a;
    for (int i = 0; i < 3; i++) begin set_in(0, 1'b0, 1'b1, 8'h7f); tick(); end
    set_in(0, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check("done_drops_valid", wr_cnt_a - c0, 0);
    check("done_still_high", bus_a.o_done, 1);

    // Random frames with random gaps
    for (int f = 0; f < 4; f++) begin
      fill_rand(16);
      c0 = wr_cnt_a;
      drive_frame(0, 4, 4, 16, $urandom_range(0, 2), 1'(f % 2));
      finish_frame(0, c0, 4);
    end

    // 5x3 map: ramp 1..15 gives 7 then 9
    fill_ramp(15);
    c0 = wr_cnt_b;
    drive_frame(1, 5, 3, 15, 0, 1'b0);
    finish_frame(1, c0, 2);
    fill_rand(15);
    c0 = wr_cnt_b;
    drive_frame(1, 5, 3, 15, 1, 1'b0);
    finish_frame(1, c0, 2);

    // Asynchronous reset mid-stream, after block (0,0) has been written
    fill_ramp(15);
    c0 = wr_cnt_b;
    drive_frame(1, 5, 3, 8, 0, 1'b0);
    repeat (2) tick();
    check("pre_reset_writes", wr_cnt_b - c0, 1);
    check("pre_reset_data", bus_b.o_wr_data, 7);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs(1);
    check_reset_outputs(0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    check("idle_after_reset_b", bus_b.o_ready, 0);
    c0 = wr_cnt_b;
    drive_frame(1, 5, 3, 15, 0, 1'b0);
    finish_frame(1, c0, 2);

    check("final_queue_a", exp_q_a.size(), 0);
    check("final_queue_b", exp_q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
